correlator_readout_sequencer: RTL and testbench

// - Sequences the correlator datapath: integration timer, snapshot strobe to the pulse/pair counters,

---
 rtl/correlator_readout_sequencer_pkg.sv | 32 +++
 rtl/correlator_readout_sequencer_if.sv | 28 ++
 rtl/correlator_readout_sequencer_integration_timer.sv | 46 ++++
 rtl/correlator_readout_sequencer.sv | 147 ++++++++++++++
 tb/tb_correlator_readout_sequencer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/correlator_readout_sequencer_pkg.sv
// Shared types and sizing helpers for the correlator readout sequencer.
// Channel counts are derived from the number of pulse inputs.
package correlator_readout_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_SEL  = 3'd2,
    ST_LOAD = 3'd3,
    ST_SEND = 3'd4,
    ST_NEXT = 3'd5
  } state_e;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  function automatic int num_correlators(input int n_inputs);
    return (n_inputs * (n_inputs - 1)) / 2;
  endfunction

  function automatic int num_channels(input int n_inputs);
    return n_inputs + num_correlators(n_inputs);
  endfunction

  function automatic int bytes_per_word(input int resolution);
    return (resolution + 7) / 8;
  endfunction

  function automatic int sel_width(input int n_channels);
    return (n_channels > 1) ? $clog2(n_channels) : 1;
  endfunction

endpackage

// File: rtl/correlator_readout_sequencer_if.sv
// Readout bus: channel select / snapshot read mux plus the UART byte handshake.
// The sequencer is the master; the counter bank and UART together form the slave side.
interface correlator_readout_sequencer_if #(
  parameter int SEL_W      = 7,
  parameter int RESOLUTION = 16
);
  logic [SEL_W-1:0]      sel;
  logic [RESOLUTION-1:0] rd_data;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    output sel,
    output tx_data,
    output tx_valid,
    input  rd_data,
    input  tx_ready
  );

  modport slave (
    input  sel,
    input  tx_data,
    input  tx_valid,
    output rd_data,
    output tx_ready
  );
endinterface

// File: rtl/correlator_readout_sequencer_integration_timer.sv
// Integration period timer: counts while enabled, held at zero otherwise,
// and flags the final cycle of each period with a registered strobe.
module correlator_readout_sequencer_integration_timer #(
  parameter int INTEGRATION_CYCLES = 50000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  output logic o_wrap
);
  import correlator_readout_sequencer_pkg::*;

  localparam int             CNT_W = $clog2(INTEGRATION_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(INTEGRATION_CYCLES - 1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             r_wrap;

  always_comb begin
    w_count_next = '0;
    if (i_enable) begin
      if (r_count == LAST) begin
        w_count_next = '0;
      end else begin
        w_count_next = r_count + CNT_W'(1);
      end
    end else begin
      w_count_next = '0;
    end
  end

  // r_wrap mirrors (r_count == LAST) so the strobe leaves a flop directly
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_wrap  <= (w_count_next == LAST);
    end
  end

  assign o_wrap = r_wrap;

endmodule

// File: rtl/correlator_readout_sequencer.sv
// Readout sequencer: snapshots the counter bank at the end of each integration period
// and streams a header byte followed by every channel word, MSB first, to the UART.
module correlator_readout_sequencer #(
  parameter int         INTEGRATION_CYCLES = 50000000,
  parameter int         RESOLUTION         = 16,
  parameter int         NUM_INPUTS         = 12,
  parameter logic [7:0] HEADER_BYTE        = correlator_readout_sequencer_pkg::HEADER_BYTE
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_enable,
  output logic                           o_integration_clk_pulse,
  output logic                           o_snapshot_load,
  output logic                           o_busy,
  output logic                           o_overrun,
  correlator_readout_sequencer_if.master bus
);
  import correlator_readout_sequencer_pkg::*;

  localparam int NUM_CORRELATORS = num_correlators(NUM_INPUTS);
  localparam int NUM_CHANNELS    = NUM_INPUTS + NUM_CORRELATORS;
  localparam int BYTES_PER_WORD  = bytes_per_word(RESOLUTION);
  localparam int SEL_W           = sel_width(NUM_CHANNELS);
  localparam int SHIFT_W         = 8 * BYTES_PER_WORD;
  localparam int IDX_W           = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(NUM_CHANNELS - 1);
  localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(BYTES_PER_WORD - 1);

  state_e             r_state;
  state_e             w_state_next;
  logic [SEL_W-1:0]   r_ch;
  logic [SHIFT_W-1:0] r_shift;
  logic [IDX_W-1:0]   r_byte_idx;
  logic               r_overrun;
  logic               w_wrap;
  logic               w_tx_valid;
  logic [7:0]         w_tx_data;
  logic               w_accept;
  logic               w_idle;

  correlator_readout_sequencer_integration_timer #(
    .INTEGRATION_CYCLES (INTEGRATION_CYCLES)
  ) u_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_enable (i_enable),
    .o_wrap   (w_wrap)
  );

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_tx_valid & bus.tx_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_wrap) w_state_next = ST_HDR;
        else        w_state_next = ST_IDLE;
      end
      ST_HDR: begin
        if (bus.tx_ready) w_state_next = ST_SEL;
        else              w_state_next = ST_HDR;
      end
      ST_SEL:  w_state_next = ST_LOAD;
      ST_LOAD: w_state_next = ST_SEND;
      ST_SEND: begin
        if (bus.tx_ready && (r_byte_idx == LAST_BYTE)) w_state_next = ST_NEXT;
        else                                           w_state_next = ST_SEND;
      end
      ST_NEXT: begin
        if (r_ch == LAST_CH) w_state_next = ST_IDLE;
        else                 w_state_next = ST_SEL;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_tx_valid = 1'b0;
    w_tx_data  = 8'h00;
    case (r_state)
      ST_HDR: begin
        w_tx_valid = 1'b1;
        w_tx_data  = HEADER_BYTE;
      end
      ST_SEND: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_shift[SHIFT_W-1 -: 8];
      end
      default: begin
        w_tx_valid = 1'b0;
        w_tx_data  = 8'h00;
      end
    endcase
  end

  // Select advances on leaving NEXT so rd_data has settled by the LOAD capture.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ch       <= '0;
      r_shift    <= '0;
      r_byte_idx <= '0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_wrap && !w_idle) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ST_LOAD: begin
          r_shift    <= SHIFT_W'(bus.rd_data);
          r_byte_idx <= '0;
        end
        ST_SEND: begin
          if (w_accept) begin
            r_shift    <= r_shift << 4'd8;
            r_byte_idx <= r_byte_idx + IDX_W'(1);
          end
        end
        ST_NEXT: begin
          if (r_ch == LAST_CH) r_ch <= '0;
          else                 r_ch <= r_ch + SEL_W'(1);
        end
        default: begin
          r_ch <= r_ch;
        end
      endcase
    end
  end

  assign o_integration_clk_pulse = w_wrap;
  assign o_snapshot_load         = w_wrap & w_idle;
  assign o_busy                  = !w_idle;
  assign o_overrun               = r_overrun;
  assign bus.sel                 = r_ch;
  assign bus.tx_valid            = w_tx_valid;
  assign bus.tx_data             = w_tx_data;

endmodule

// File: tb/tb_correlator_readout_sequencer.sv
// Directed bench: 3 inputs (6 channels), 200-cycle periods, 16-bit and 12-bit instances.
`timescale 1ns/1ps
module tb_correlator_readout_sequencer;
  import correlator_readout_sequencer_pkg::*;

  localparam int IC   = 200;
  localparam int NI   = 3;
  localparam int NCH  = num_channels(NI);
  localparam int SELW = sel_width(NCH);
  localparam int FLEN = 1 + NCH * 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic pulse16, snap16, busy16, ovr16;
  logic pulse12, snap12, busy12, ovr12;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  correlator_readout_sequencer_if #(.SEL_W(SELW), .RESOLUTION(16)) bus16 ();
  correlator_readout_sequencer_if #(.SEL_W(SELW), .RESOLUTION(12)) bus12 ();

  correlator_readout_sequencer #(
    .INTEGRATION_CYCLES (IC), .RESOLUTION (16), .NUM_INPUTS (NI), .HEADER_BYTE (8'hA5)
  ) dut16 (
    .i_clk (clk), .i_reset (reset), .i_enable (enable),
    .o_integration_clk_pulse (pulse16), .o_snapshot_load (snap16),
    .o_busy (busy16), .o_overrun (ovr16), .bus (bus16)
  );

  correlator_readout_sequencer #(
    .INTEGRATION_CYCLES (IC), .RESOLUTION (12), .NUM_INPUTS (NI), .HEADER_BYTE (8'hA5)
  ) dut12 (
    .i_clk (clk), .i_reset (reset), .i_enable (enable),
    .o_integration_clk_pulse (pulse12), .o_snapshot_load (snap12),
    .o_busy (busy12), .o_overrun (ovr12), .bus (bus12)
  );

  // Registered read mux: data appears one cycle after sel changes
  always @(posedge clk) bus16.rd_data <= 16'h1234 + 16'(bus16.sel);
  assign bus12.rd_data  = 12'hABC;
  assign bus12.tx_ready = 1'b1;

  logic [7:0] q16[$];
  logic [7:0] q12[$];
  int         pulse_cyc[$];
  int         snap_cyc[$];
  int         cyc = 0;
  int         stall_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  // Sample 2 ns after the falling edge: outputs and inputs are both settled for the next rising edge
  always @(negedge clk) begin
    #2;
    cyc++;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!bus16.tx_valid || (bus16.tx_data != prev_data))) stall_err++;
      prev_stall = bus16.tx_valid && !bus16.tx_ready;
      prev_data  = bus16.tx_data;
      if (bus16.tx_valid && bus16.tx_ready) q16.push_back(bus16.tx_data);
      if (bus12.tx_valid && bus12.tx_ready) q12.push_back(bus12.tx_data);
      if (pulse16) pulse_cyc.push_back(cyc);
      if (snap16)  snap_cyc.push_back(cyc);
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    q16.delete();
    q12.delete();
    pulse_cyc.delete();
    snap_cyc.delete();
    stall_err = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    enable = 1'b0;
    bus16.tx_ready = 1'b1;
    tick(3);
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic check_frame(input string tag, input int base);
    check_value({tag, "_hdr"}, 32'(q16[base]), 32'h0000_00A5);
    for (int c = 0; c < NCH; c++) begin
      check_value($sformatf("%s_ch%0d_hi", tag, c), 32'(q16[base + 1 + 2*c]), 32'h0000_0012);
      check_value($sformatf("%s_ch%0d_lo", tag, c), 32'(q16[base + 2 + 2*c]), 32'h34 + 32'(c));
    end
  endtask

  int c_en;
  int waited;

  initial begin
    bus16.tx_ready = 1'b1;

    // Reset state
    tick(2);
    check_value("rst_pulse", 32'(pulse16), 32'h0);
    check_value("rst_snap", 32'(snap16), 32'h0);
    check_value("rst_busy", 32'(busy16), 32'h0);
    check_value("rst_overrun", 32'(ovr16), 32'h0);
    check_value("rst_tx_valid", 32'(bus16.tx_valid), 32'h0);
    check_value("rst_sel", 32'(bus16.sel), 32'h0);
    apply_reset();

    // Timer held while disabled
    tick(250);
    check_value("disabled_pulses", 32'(pulse_cyc.size()), 32'd0);

    // Basic frames and timing
    apply_reset();
    enable = 1'b1;
    c_en = cyc;
    tick(450);
    check_value("pulse_count", 32'(pulse_cyc.size()), 32'd2);
    check_value("snap_count", 32'(snap_cyc.size()), 32'd2);
    check_value("pulse0_cycle", 32'(pulse_cyc[0] - c_en - 1), 32'd199);
    check_value("pulse1_cycle", 32'(pulse_cyc[1] - c_en - 1), 32'd399);
    check_value("snap0_cycle", 32'(snap_cyc[0] - c_en - 1), 32'd199);
    check_value("byte_count", 32'(q16.size()), 32'(2 * FLEN));
    check_frame("basic0", 0);
    check_frame("basic1", FLEN);
    check_value("basic_busy_end", 32'(busy16), 32'h0);
    check_value("basic_overrun", 32'(ovr16), 32'h0);
    check_value("r12_hdr", 32'(q12[0]), 32'h0000_00A5);
    check_value("r12_w0_hi", 32'(q12[1]), 32'h0000_000A);
    check_value("r12_w0_lo", 32'(q12[2]), 32'h0000_00BC);
    check_value("r12_w1_hi", 32'(q12[3]), 32'h0000_000A);
    check_value("r12_w1_lo", 32'(q12[4]), 32'h0000_00BC);
    check_value("r12_len", 32'(q12.size()), 32'(2 * FLEN));

    // Backpressure: ready high ~30% of cycles
    apply_reset();
    enable = 1'b1;
    for (int i = 0; i < 440; i++) begin
      @(negedge clk);
      bus16.tx_ready = ($urandom_range(0, 9) < 3);
    end
    @(negedge clk);
    bus16.tx_ready = 1'b1;
    tick(60);
    check_value("bp_byte_count", 32'(q16.size()), 32'(2 * FLEN));
    check_frame("bp0", 0);
    check_frame("bp1", FLEN);
    check_value("bp_stall_stable", 32'(stall_err), 32'd0);
    check_value("bp_overrun", 32'(ovr16), 32'h0);

    // Overrun: UART stalls across a full period
    apply_reset();
    enable = 1'b1;
    bus16.tx_ready = 1'b0;
    tick(450);
    check_value("ovr_flag", 32'(ovr16), 32'h1);
    check_value("ovr_pulses", 32'(pulse_cyc.size()), 32'd2);
    check_value("ovr_snaps", 32'(snap_cyc.size()), 32'd1);
    bus16.tx_ready = 1'b1;
    tick(60);
    check_value("ovr_byte_count", 32'(q16.size()), 32'(FLEN));
    check_frame("ovr", 0);
    check_value("ovr_stall_stable", 32'(stall_err), 32'd0);
    check_value("ovr_sticky", 32'(ovr16), 32'h1);
    check_value("ovr_busy_end", 32'(busy16), 32'h0);

    // Reset in the middle of SEND
    apply_reset();
    enable = 1'b1;
    waited = 0;
    while (!((q16.size() >= 3) && bus16.tx_valid) && (waited < 400)) begin
      @(negedge clk);
      waited++;
    end
    check_value("midsend_reached", 32'(waited < 400), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check_value("midsend_tx_valid", 32'(bus16.tx_valid), 32'h0);
    check_value("midsend_busy", 32'(busy16), 32'h0);
    check_value("midsend_sel", 32'(bus16.sel), 32'h0);
    reset = 1'b0;
    clear_logs();
    tick(260);
    check_value("restart_byte_count", 32'(q16.size()), 32'(FLEN));
    check_frame("restart", 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
